// File: rtl/bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// bist_response_analyzer
//
// Read-back end of the MBIST memory path. Every read the BIST controller issues
// (cmp_en) carries the address and the data it expects back. The request is
// carried through a shift register whose depth matches the memory read latency.
// When it leaves that register it is compared with mem_q in the same cycle.
// The block keeps these results:
//   - a sticky fail flag
//   - the address and syndrome of the first failure
//   - a saturating error count
//   - an end-of-test pass/fail once the controller signals bist_done and the
//     pipeline has drained
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous reset, active-high
//   NbarT            0: normal mode, 1: test mode
//   clear            synchronous clear of results, pipeline and FSM
//   cmp_en           a read is issued this cycle and must be compared
//   bist_addr        address of that read
//   exp_data         data expected back for that read
//   mem_q            memory read data, valid RD_LATENCY cycles after cmp_en
//   bist_done        pulse: the controller has issued its last read
//   err_pulse        one-cycle pulse per mismatch (registered)
//   fail             sticky mismatch flag
//   first_fail_addr  address of the first mismatch
//   first_fail_syn   mem_q ^ expected at the first mismatch
//   err_cnt          mismatch count, saturates at all-ones
//   result_valid     end-of-test result is stable (FSM in DONE)
//   pass             result_valid & ~fail
//   dbg_state_o      current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: cmp_en is a valid with no ready. A request is taken in any cycle
// where cmp_en=1, NbarT=1, clear=0 and the FSM is in IDLE or RUN. Otherwise the
// request is dropped silently. The controller never stalls.
//
// RD_LATENCY must be in 1..4.
// -----------------------------------------------------------------------------
module bist_response_analyzer #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     NbarT,
  input  logic                     clear,
  input  logic                     cmp_en,
  input  logic [ADDR_WIDTH-1:0]    bist_addr,
  input  logic [DATA_WIDTH-1:0]    exp_data,
  input  logic [DATA_WIDTH-1:0]    mem_q,
  input  logic                     bist_done,
  output logic                     err_pulse,
  output logic                     fail,
  output logic [ADDR_WIDTH-1:0]    first_fail_addr,
  output logic [DATA_WIDTH-1:0]    first_fail_syn,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     result_valid,
  output logic                     pass,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

  state_e state_q, state_d;

  // Request pipeline: stage 0 is loaded on accept. Stage RD_LATENCY-1 is the
  // exiting stage, which lines up with mem_q.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_WIDTH-1:0] addr_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] addr_d [RD_LATENCY];
  logic [DATA_WIDTH-1:0] exp_q  [RD_LATENCY];
  logic [DATA_WIDTH-1:0] exp_d  [RD_LATENCY];

  logic                     err_pulse_q, err_pulse_d;
  logic                     fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]    ffa_q, ffa_d;
  logic [DATA_WIDTH-1:0]    ffs_q, ffs_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                  accept;
  logic                  exit_vld;
  logic [ADDR_WIDTH-1:0] exit_addr;
  logic [DATA_WIDTH-1:0] syndrome;
  logic                  mismatch;
  logic                  busy_next;

  // ---------------------------------------------------------------------------
  // Accept and compare
  // ---------------------------------------------------------------------------
  assign accept = cmp_en & NbarT & ~clear &
                  ((state_q == ST_IDLE) | (state_q == ST_RUN));

  assign exit_vld  = vld_q[RD_LATENCY-1];
  assign exit_addr = addr_q[RD_LATENCY-1];
  assign syndrome  = mem_q ^ exp_q[RD_LATENCY-1];
  assign mismatch  = exit_vld & (|syndrome);

  // Entries that are still in flight after this edge. The exiting stage is
  // excluded, because it is compared on this edge. This lets DRAIN move to
  // DONE on the same edge that records the final compare, so pass already
  // reflects it.
  always_comb begin
    busy_next = 1'b0;
    for (int i = 0; i < RD_LATENCY - 1; i++) begin
      busy_next = busy_next | vld_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline next state
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_d     = '0;
    vld_d[0]  = accept;
    addr_d[0] = bist_addr;
    exp_d[0]  = exp_data;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
      exp_d[i]  = exp_q[i-1];
    end
    if (clear) begin
      vld_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (NbarT) state_d = ST_RUN;
      end
      ST_RUN: begin
        // bist_done wins over a same-cycle NbarT drop.
        if (bist_done)   state_d = ST_DRAIN;
        else if (!NbarT) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // NbarT is deliberately ignored here. A drain always completes.
        if (!busy_next) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Result next state; clear beats a same-cycle mismatch
  // ---------------------------------------------------------------------------
  always_comb begin
    err_pulse_d = mismatch;
    fail_d      = fail_q | mismatch;
    ffa_d       = ffa_q;
    ffs_d       = ffs_q;
    cnt_d       = cnt_q;
    if (mismatch && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // Only the first mismatch since clear/reset is captured.
    if (mismatch && !fail_q) begin
      ffa_d = exit_addr;
      ffs_d = syndrome;
    end
    if (clear) begin
      err_pulse_d = 1'b0;
      fail_d      = 1'b0;
      ffa_d       = '0;
      ffs_d       = '0;
      cnt_d       = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vld_q       <= '0;
      err_pulse_q <= 1'b0;
      fail_q      <= 1'b0;
      ffa_q       <= '0;
      ffs_q       <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      err_pulse_q <= err_pulse_d;
      fail_q      <= fail_d;
      ffa_q       <= ffa_d;
      ffs_q       <= ffs_d;
      cnt_q       <= cnt_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        addr_q[i] <= addr_d[i];
        exp_q[i]  <= exp_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign err_pulse       = err_pulse_q;
  assign fail            = fail_q;
  assign first_fail_addr = ffa_q;
  assign first_fail_syn  = ffs_q;
  assign err_cnt         = cnt_q;
  assign result_valid    = (state_q == ST_DONE);
  assign pass            = (state_q == ST_DONE) & ~fail_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// tb_bist_response_analyzer
//
// Two analyzers share the controller-side stimulus:
//   dut_a: RD_LATENCY=1, ERR_CNT_WIDTH=4
//   dut_b: RD_LATENCY=3, ERR_CNT_WIDTH=8
// A small memory model supplies each one with mem_q at its own read latency.
// Expected values are written out by hand in each check.
// -----------------------------------------------------------------------------
module tb_bist_response_analyzer;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_DRAIN = 2;
  localparam int ST_DONE  = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       nbart;
  logic       clear;
  logic       cmp_en;
  logic       bist_done;
  logic [7:0] bist_addr;
  logic [7:0] exp_data;

  // memory model: combinational array, registered read, per-DUT latency
  logic [7:0] mem_arr [256];
  logic [7:0] mem_q_a;
  logic [7:0] rd_b [3];
  logic [7:0] mem_q_b;

  always @(posedge clk) begin
    mem_q_a <= mem_arr[bist_addr];
    rd_b[0] <= mem_arr[bist_addr];
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign mem_q_b = rd_b[2];

  // dut outputs
  logic       err_pulse_a, fail_a, rv_a, pass_a;
  logic [7:0] ffa_a, ffs_a;
  logic [3:0] cnt_a;
  logic [1:0] st_a;
  logic       err_pulse_b, fail_b, rv_b, pass_b;
  logic [7:0] ffa_b, ffs_b;
  logic [7:0] cnt_b;
  logic [1:0] st_b;

  bist_response_analyzer #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1), .ERR_CNT_WIDTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .NbarT(nbart), .clear(clear), .cmp_en(cmp_en),
    .bist_addr(bist_addr), .exp_data(exp_data), .mem_q(mem_q_a),
    .bist_done(bist_done), .err_pulse(err_pulse_a), .fail(fail_a),
    .first_fail_addr(ffa_a), .first_fail_syn(ffs_a), .err_cnt(cnt_a),
    .result_valid(rv_a), .pass(pass_a), .dbg_state_o(st_a)
  );

  bist_response_analyzer #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(3), .ERR_CNT_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst(rst), .NbarT(nbart), .clear(clear), .cmp_en(cmp_en),
    .bist_addr(bist_addr), .exp_data(exp_data), .mem_q(mem_q_b),
    .bist_done(bist_done), .err_pulse(err_pulse_b), .fail(fail_b),
    .first_fail_addr(ffa_b), .first_fail_syn(ffs_b), .err_cnt(cnt_b),
    .result_valid(rv_b), .pass(pass_b), .dbg_state_o(st_b)
  );

  // scoreboard counters
  int total = 0;
  int bad   = 0;
  int np_a  = 0;   // err_pulse cycles seen on dut_a
  int np_b  = 0;   // err_pulse cycles seen on dut_b

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // driver tasks: one clock, then settle 1 time unit past the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (err_pulse_a) np_a++;
    if (err_pulse_b) np_b++;
  endtask

  task automatic read(input logic [7:0] a, input logic [7:0] e);
    cmp_en    = 1'b1;
    bist_addr = a;
    exp_data  = e;
    step();
    cmp_en    = 1'b0;
  endtask

  task automatic clear_all();
    clear = 1'b1;
    step();
    clear = 1'b0;
    np_a  = 0;
    np_b  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] bad_exp;

  initial begin
    rst       = 1'b1;
    nbart     = 1'b0;
    clear     = 1'b0;
    cmp_en    = 1'b0;
    bist_done = 1'b0;
    bist_addr = 8'h00;
    exp_data  = 8'h00;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'h3C;
    mem_arr[5] = 8'hA5;
    mem_arr[9] = 8'hA5;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_fail_a",  32'(fail_a), 0);
    check("rst_cnt_a",   32'(cnt_a), 0);
    check("rst_rv_a",    32'(rv_a), 0);
    check("rst_pass_a",  32'(pass_a), 0);
    check("rst_pulse_a", 32'(err_pulse_a), 0);
    check("rst_ffa_a",   32'(ffa_a), 0);
    check("rst_ffs_a",   32'(ffs_a), 0);
    check("rst_st_a",    32'(st_a), ST_IDLE);
    check("rst_cnt_b",   32'(cnt_b), 0);
    check("rst_st_b",    32'(st_b), ST_IDLE);

    // 1: 16 clean reads then bist_done
    nbart = 1'b1;
    for (int i = 0; i < 16; i++) read(8'(i), mem_arr[i]);
    bist_done = 1'b1;
    step();
    bist_done = 1'b0;
    check("t1_st_a_drain", 32'(st_a), ST_DRAIN);
    check("t1_rv_a_early", 32'(rv_a), 0);
    step();
    check("t1_rv_a",       32'(rv_a), 1);
    check("t1_pass_a",     32'(pass_a), 1);
    check("t1_cnt_a",      32'(cnt_a), 0);
    check("t1_st_b_drain", 32'(st_b), ST_DRAIN);
    check("t1_rv_b_early", 32'(rv_b), 0);
    step();
    check("t1_rv_b",       32'(rv_b), 1);
    check("t1_pass_b",     32'(pass_b), 1);
    check("t1_cnt_b",      32'(cnt_b), 0);
    check("t1_np_a",       32'(np_a), 0);
    check("t1_np_b",       32'(np_b), 0);

    // DONE ignores cmp_en and bist_done
    cmp_en = 1'b1; bist_addr = 8'h05; exp_data = 8'h00; bist_done = 1'b1;
    step();
    step();
    cmp_en = 1'b0; bist_done = 1'b0;
    repeat (4) step();
    check("done_hold_st_a",   32'(st_a), ST_DONE);
    check("done_hold_cnt_a",  32'(cnt_a), 0);
    check("done_hold_pass_b", 32'(pass_b), 1);
    check("done_hold_cnt_b",  32'(cnt_b), 0);
    clear_all();
    check("clr_st_a", 32'(st_a), ST_IDLE);
    check("clr_rv_a", 32'(rv_a), 0);

    // 2: two mismatches at 0x05 and 0x09 (mem 0xA5, expected 0xFF)
    read(8'h04, mem_arr[4]);
    read(8'h05, 8'hFF);
    read(8'h06, mem_arr[6]);
    read(8'h09, 8'hFF);
    bist_done = 1'b1;
    step();
    bist_done = 1'b0;
    repeat (4) step();
    check("t2_ffa_a",  32'(ffa_a), 32'h05);
    check("t2_ffs_a",  32'(ffs_a), 32'h5A);
    check("t2_cnt_a",  32'(cnt_a), 2);
    check("t2_np_a",   32'(np_a), 2);
    check("t2_pass_a", 32'(pass_a), 0);
    check("t2_rv_a",   32'(rv_a), 1);
    check("t2_ffa_b",  32'(ffa_b), 32'h05);
    check("t2_ffs_b",  32'(ffs_b), 32'h5A);
    check("t2_cnt_b",  32'(cnt_b), 2);
    check("t2_np_b",   32'(np_b), 2);
    check("t2_fail_b", 32'(fail_b), 1);
    check("t2_pass_b", 32'(pass_b), 0);

    // 3: 20 mismatches; 4-bit counter saturates
    clear_all();
    repeat (20) read(8'h05, 8'h00);
    repeat (4) step();
    check("t3_cnt_a",  32'(cnt_a), 32'hF);
    check("t3_fail_a", 32'(fail_a), 1);
    check("t3_ffs_a",  32'(ffs_a), 32'hA5);
    check("t3_np_a",   32'(np_a), 20);
    check("t3_cnt_b",  32'(cnt_b), 20);
    nbart = 1'b0;
    step();
    check("t3_run_to_idle", 32'(st_a), ST_IDLE);
    // bist_done in IDLE and cmp_en in normal mode are ignored
    bist_done = 1'b1; cmp_en = 1'b1; bist_addr = 8'h05; exp_data = 8'h00;
    step();
    bist_done = 1'b0; cmp_en = 1'b0;
    repeat (4) step();
    check("idle_done_st_a", 32'(st_a), ST_IDLE);
    check("normal_cnt_b",   32'(cnt_b), 20);
    check("normal_np_b",    32'(np_b), 20);

    // 4: back-to-back reads, bist_done on the last one, NbarT dropped in DRAIN
    nbart = 1'b1;
    clear_all();
    for (int k = 0; k < 5; k++) read(8'(16 + k), mem_arr[16 + k]);
    bad_exp   = ~mem_arr[21];
    cmp_en    = 1'b1; bist_addr = 8'd21; exp_data = bad_exp; bist_done = 1'b1;
    step();
    cmp_en = 1'b0; bist_done = 1'b0; nbart = 1'b0;
    check("t4_st_b_1", 32'(st_b), ST_DRAIN);
    step();
    check("t4_st_b_2", 32'(st_b), ST_DRAIN);
    step();
    check("t4_st_b_3",  32'(st_b), ST_DRAIN);
    check("t4_cnt_b_3", 32'(cnt_b), 0);
    check("t4_rv_b_3",  32'(rv_b), 0);
    step();
    check("t4_st_b_done", 32'(st_b), ST_DONE);
    check("t4_rv_b",      32'(rv_b), 1);
    check("t4_cnt_b",     32'(cnt_b), 1);
    check("t4_pulse_b",   32'(err_pulse_b), 1);
    check("t4_ffa_b",     32'(ffa_b), 21);
    check("t4_ffs_b",     32'(ffs_b), 32'hFF);
    check("t4_pass_b",    32'(pass_b), 0);
    check("t4_st_a",      32'(st_a), ST_DONE);
    check("t4_cnt_a",     32'(cnt_a), 1);

    // 5: clear in the same cycle a mismatch exits (dut_a) and a cmp_en arrives
    nbart = 1'b1;
    clear_all();
    read(8'h05, 8'h00);
    cmp_en = 1'b1; bist_addr = 8'h09; exp_data = 8'h00; clear = 1'b1;
    step();
    clear = 1'b0; cmp_en = 1'b0;
    check("t5_fail_a",  32'(fail_a), 0);
    check("t5_cnt_a",   32'(cnt_a), 0);
    check("t5_pulse_a", 32'(err_pulse_a), 0);
    check("t5_st_a",    32'(st_a), ST_IDLE);
    repeat (5) step();
    check("t5_cnt_a_later", 32'(cnt_a), 0);
    check("t5_np_a",        32'(np_a), 0);
    check("t5_cnt_b",       32'(cnt_b), 0);
    check("t5_fail_b",      32'(fail_b), 0);
    check("t5_np_b",        32'(np_b), 0);

    // 6: async reset with two requests in flight on dut_b
    clear_all();
    read(8'h05, 8'h00);
    read(8'h05, 8'h00);
    read(8'h05, 8'h00);
    step();
    check("t6_pre_cnt_b", 32'(cnt_b), 1);
    check("t6_pre_cnt_a", 32'(cnt_a), 3);
    #2;
    rst = 1'b1;
    #2;
    check("t6_rst_fail_b",  32'(fail_b), 0);
    check("t6_rst_cnt_b",   32'(cnt_b), 0);
    check("t6_rst_ffa_b",   32'(ffa_b), 0);
    check("t6_rst_ffs_b",   32'(ffs_b), 0);
    check("t6_rst_st_b",    32'(st_b), ST_IDLE);
    check("t6_rst_pulse_b", 32'(err_pulse_b), 0);
    check("t6_rst_cnt_a",   32'(cnt_a), 0);
    check("t6_rst_fail_a",  32'(fail_a), 0);
    rst  = 1'b0;
    np_a = 0;
    np_b = 0;
    repeat (6) step();
    check("t6_np_b",   32'(np_b), 0);
    check("t6_cnt_b",  32'(cnt_b), 0);
    check("t6_fail_b", 32'(fail_b), 0);
    check("t6_np_a",   32'(np_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
